// File: rtl/instr_fetch.sv
// RV32I instruction-fetch initiator: one word request per cycle, data returns one cycle later.
// Optional static prediction (JAL / backward branch) is compiled in with `define PREDICT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l_pause,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_renable,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addrpred,
  output logic        mem_renablepred,
  input  logic [31:0] mem_rdata_pred,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_pred_taken
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        inflight_q, inflight_d;
  logic        redir_pend_q, redir_pend_d;

  logic [31:0] redirect_pc_al;
  logic [31:0] nxt;
  logic        pred_taken;
  logic [31:0] pred_target;

  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

`ifdef PREDICT_EN
  logic [31:0] j_imm, b_imm;
  logic        unused_ok;

  // Predecode the word returning on the prediction port; only meaningful while a fetch is in flight.
  always_comb begin
    j_imm       = {{12{mem_rdata_pred[31]}}, mem_rdata_pred[19:12], mem_rdata_pred[20],
                   mem_rdata_pred[30:21], 1'b0};
    b_imm       = {{20{mem_rdata_pred[31]}}, mem_rdata_pred[7], mem_rdata_pred[30:25],
                   mem_rdata_pred[11:8], 1'b0};
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    if (inflight_q) begin
      if (mem_rdata_pred[6:0] == 7'h6F) begin
        pred_taken  = 1'b1;
        pred_target = pc_q + j_imm;
      end else if (mem_rdata_pred[6:0] == 7'h63 && mem_rdata_pred[31]) begin
        pred_taken  = 1'b1;
        pred_target = pc_q + b_imm;
      end
    end
    pred_target[1:0] = 2'b00;
  end

  assign mem_renablepred = !l_pause && !rst;
  assign unused_ok       = ^redirect_pc[1:0];
`else
  logic unused_ok;

  assign pred_taken      = 1'b0;
  assign pred_target     = 32'h0;
  assign mem_renablepred = 1'b0;
  assign unused_ok       = ^{redirect_pc[1:0], mem_rdata_pred, pred_target};
`endif

  always_comb begin
    if (redirect_valid)       nxt = redirect_pc_al;
    else if (redir_pend_q)    nxt = redir_pc_q;
    else if (!inflight_q)     nxt = RESET_PC;
    else if (pred_taken)      nxt = pred_target;
    else                      nxt = pc_q + 32'd4;

    pc_d         = pc_q;
    inflight_d   = inflight_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    if (!l_pause) begin
      pc_d         = nxt;
      inflight_d   = 1'b1;
      redir_pend_d = 1'b0;
    end else if (redirect_valid) begin
      // Memory is frozen during a pause, so the redirect is parked until the stall lifts.
      redir_pend_d = 1'b1;
      redir_pc_d   = redirect_pc_al;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  always_comb begin
    if (rst)           mem_addr = RESET_PC;
    else if (l_pause)  mem_addr = pc_q;
    else               mem_addr = nxt;
    mem_renable      = !rst && !l_pause;
    mem_addrpred     = mem_addr;
    instr_valid      = !rst && inflight_q && !redirect_valid && !redir_pend_q;
    instr            = mem_rdata;
    instr_pc         = pc_q;
    instr_pred_taken = pred_taken && instr_valid;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector tables plus a randomized run against a transaction-level model.
module tb_instr_fetch;

`ifdef PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, l_pause, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr, mem_addrpred;
  logic        mem_renable, mem_renablepred;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_rdata_pred = 32'h0;
  logic        instr_valid, instr_pred_taken;
  logic [31:0] instr, instr_pc;

  logic [31:0] mem_arr [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .l_pause(l_pause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_renable(mem_renable), .mem_rdata(mem_rdata),
    .mem_addrpred(mem_addrpred), .mem_renablepred(mem_renablepred),
    .mem_rdata_pred(mem_rdata_pred),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pred_taken(instr_pred_taken)
  );

  // Instruction memory: registered read, holds its output when not enabled.
  always @(posedge clk) begin
    if (mem_renable)     mem_rdata      <= mem_arr[mem_addr[9:2]];
    if (mem_renablepred) mem_rdata_pred <= mem_arr[mem_addrpred[9:2]];
  end

  typedef struct {
    bit          rst;
    bit          pause;
    bit          rv;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    bit          e_ren;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_pt;
  } vec_t;

  function automatic vec_t mk(bit r, bit p, bit v, logic [31:0] rp,
                              logic [31:0] a, bit en, bit vl, logic [31:0] pc, bit pt);
    vec_t x;
    x.rst = r; x.pause = p; x.rv = v; x.rpc = rp;
    x.e_addr = a; x.e_ren = en; x.e_valid = vl; x.e_pc = pc; x.e_pt = pt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs(input logic [31:0] e_addr, input bit e_ren, input bit e_valid,
                               input logic [31:0] e_pc, input bit e_pt);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_addrpred", mem_addrpred, e_addr);
    chk("mem_renable", 32'(mem_renable), 32'(e_ren));
    chk("mem_renablepred", 32'(mem_renablepred), 32'(e_ren & PRED));
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("instr_pred_taken", 32'(instr_pred_taken), 32'(e_valid & e_pt));
    if (e_valid) begin
      chk("instr_pc", instr_pc, e_pc);
      chk("instr", instr, mem_arr[e_pc[9:2]]);
    end
  endtask

  task automatic drive(input bit r, input bit p, input bit v, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst = r; l_pause = p; redirect_valid = v; redirect_pc = rp;
    #4;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.rst, v.pause, v.rv, v.rpc);
    check_outputs(v.e_addr, v.e_ren, v.e_valid, v.e_pc, v.e_pt);
  endtask

  // Static prediction rule computed from the immediate fields with plain arithmetic.
  function automatic void predecode(input logic [31:0] pc, input logic [31:0] w,
                                    output bit taken, output logic [31:0] tgt);
    int imm;
    taken = 1'b0;
    imm   = 0;
    if (w[6:0] == 7'h6F) begin
      taken = 1'b1;
      imm = int'({22'd0, w[30:21]}) * 2 + int'({31'd0, w[20]}) * 2048
          + int'({24'd0, w[19:12]}) * 4096 - (w[31] ? 1048576 : 0);
    end else if (w[6:0] == 7'h63 && w[31]) begin
      taken = 1'b1;
      imm = int'({28'd0, w[11:8]}) * 2 + int'({26'd0, w[30:25]}) * 32
          + int'({31'd0, w[7]}) * 2048 - 4096;
    end
    tgt = (pc + 32'(imm)) & 32'hFFFF_FFFC;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] m_pc, m_pend_pc, nxt, tgt, w;
    bit          m_busy, m_pend, pt, r, p, v, e_valid;
    logic [31:0] rp;

    rst = 1'b1; l_pause = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 256; i++) mem_arr[i] = NOP;

    //              rst pause rv  rpc            addr          ren valid pc           pt
    tbl.push_back(mk(1, 0, 0, 32'h0,          32'h0,         0, 0, 32'h0,         0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          32'h0,         0, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h0,         1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h4,         1, 1, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h8,         1, 1, 32'h4,         0));
    tbl.push_back(mk(0, 1, 0, 32'h0,          32'h8,         0, 1, 32'h8,         0));
    tbl.push_back(mk(0, 1, 0, 32'h0,          32'h8,         0, 1, 32'h8,         0));
    tbl.push_back(mk(0, 1, 0, 32'h0,          32'h8,         0, 1, 32'h8,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'hC,         1, 1, 32'h8,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h10,        1, 1, 32'hC,         0));
    tbl.push_back(mk(0, 0, 1, 32'h40,         32'h40,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h44,        1, 1, 32'h40,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h48,        1, 1, 32'h44,        0));
    tbl.push_back(mk(0, 1, 1, 32'h80,         32'h48,        0, 0, 32'h0,         0));
    tbl.push_back(mk(0, 1, 0, 32'h0,          32'h48,        0, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h80,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h84,        1, 1, 32'h80,        0));
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC, 1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h0,         1, 1, 32'hFFFF_FFFC, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h4,         1, 1, 32'h0,         0));
    tbl.push_back(mk(0, 1, 1, 32'h100,        32'h4,         0, 0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          32'h0,         0, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h0,         1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h4,         1, 1, 32'h0,         0));
    tbl.push_back(mk(0, 1, 1, 32'h200,        32'h4,         0, 0, 32'h0,         0));
    tbl.push_back(mk(0, 1, 1, 32'h300,        32'h4,         0, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h300,       1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h304,       1, 1, 32'h300,       0));
    foreach (tbl[i]) run_vec(tbl[i]);

    tbl.delete();
    mem_arr[32'h10 >> 2] = 32'h0200_006F;  // JAL x0,+32
    mem_arr[32'h20 >> 2] = 32'hFE00_0CE3;  // BEQ x0,x0,-8
    mem_arr[32'h24 >> 2] = 32'h0000_0463;  // BEQ x0,x0,+8
`ifdef PREDICT_EN
    tbl.push_back(mk(0, 0, 1, 32'h10,         32'h10,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h30,        1, 1, 32'h10,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h34,        1, 1, 32'h30,        0));
    tbl.push_back(mk(0, 0, 1, 32'h20,         32'h20,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h18,        1, 1, 32'h20,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h1C,        1, 1, 32'h18,        0));
    tbl.push_back(mk(0, 0, 1, 32'h24,         32'h24,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h28,        1, 1, 32'h24,        0));
    tbl.push_back(mk(0, 0, 1, 32'h10,         32'h10,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 1, 32'h60,         32'h60,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h64,        1, 1, 32'h60,        0));
    tbl.push_back(mk(0, 0, 1, 32'h10,         32'h10,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 1, 0, 32'h0,          32'h10,        0, 1, 32'h10,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h30,        1, 1, 32'h10,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h34,        1, 1, 32'h30,        0));
`else
    tbl.push_back(mk(0, 0, 1, 32'h10,         32'h10,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h14,        1, 1, 32'h10,        0));
    tbl.push_back(mk(0, 0, 1, 32'h20,         32'h20,        1, 0, 32'h0,         0));
    tbl.push_back(mk(0, 0, 0, 32'h0,          32'h24,        1, 1, 32'h20,        0));
`endif
    foreach (tbl[i]) run_vec(tbl[i]);

    // Randomized program and control stream against the reference model.
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 4))
        0: mem_arr[i] = NOP;
        1: mem_arr[i] = ($urandom & 32'hFFFF_F000) | 32'h0000_006F;
        2: mem_arr[i] = ($urandom & 32'h7E00_0F80) | 32'h8000_0063;
        3: mem_arr[i] = ($urandom & 32'h7E00_0F80) | 32'h0000_0063;
        default: mem_arr[i] = $urandom;
      endcase
    end
    m_pc = 32'h0; m_busy = 1'b0; m_pend = 1'b0; m_pend_pc = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      r  = (c == 0) || ($urandom_range(0, 99) == 0);
      p  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 9) == 0);
      rp = $urandom;
      drive(r, p, v, rp);
      if (r) begin
        check_outputs(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        m_pc = 32'h0; m_busy = 1'b0; m_pend = 1'b0; m_pend_pc = 32'h0;
      end else begin
        w = mem_arr[m_pc[9:2]];
        predecode(m_pc, w, pt, tgt);
        pt = pt && PRED && m_busy;
        if (v)            nxt = rp & 32'hFFFF_FFFC;
        else if (m_pend)  nxt = m_pend_pc;
        else if (!m_busy) nxt = 32'h0;
        else if (pt)      nxt = tgt;
        else              nxt = m_pc + 32'd4;
        e_valid = m_busy && !v && !m_pend;
        check_outputs(p ? m_pc : nxt, !p, e_valid, m_pc, pt);
        if (!p) begin
          m_pc = nxt; m_busy = 1'b1; m_pend = 1'b0;
        end else if (v) begin
          m_pend = 1'b1; m_pend_pc = rp & 32'hFFFF_FFFC;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
